// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall, branch flush and memory-wait freeze control
// for a five-stage pipeline, with saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic             branch_taken,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam int WW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             mem_acc, lu_hit, stall_i, flush_i, lu_stall;

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        return (mem_regwrite && mem_rd != '0 && mem_rd == src) ? 2'b10 :
               (wb_regwrite && wb_rd != '0 && wb_rd == src)    ? 2'b01 : 2'b00;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // The release cycle (MEM_WAIT, wcnt==0) returns to RUN without re-arming on the same access.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (state_q == RUN) begin
            if (mem_acc && MEM_LAT > 0) begin
                state_d = MEM_WAIT;
                wcnt_d  = WW'(MEM_LAT - 1);
            end
        end else if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - 1'b1;
        end else begin
            state_d = RUN;
        end
        stall_d = ((stall_i || lu_stall) && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        flush_d = (flush_i && flush_q != '1) ? flush_q + 1'b1 : flush_q;
    end

    // Priority: memory wait, then branch flush, then load-use stall; reset forces idle outputs.
    always_comb begin
        mem_acc        = mem_memread || mem_memwrite;
        lu_hit         = ex_memread && ex_regwrite && ex_rd != '0 &&
                         (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        stall_i        = (state_q == RUN) ? (mem_acc && MEM_LAT > 0) : (wcnt_q != '0);
        flush_i        = !stall_i && branch_taken;
        lu_stall       = !stall_i && !branch_taken && lu_hit;
        pc_write_en    = rst || !(stall_i || lu_stall);
        if_id_write_en = rst || !(stall_i || lu_stall);
        id_ex_bubble   = !rst && lu_stall;
        if_id_flush    = !rst && flush_i;
        id_ex_flush    = !rst && flush_i;
        mem_stall      = !rst && stall_i;
        fwd_a          = rst ? 2'b00 : fwd_sel(ex_rs);
        fwd_b          = rst ? 2'b00 : fwd_sel(ex_rt);
        stall_count    = stall_q;
        flush_count    = flush_q;
    end
endmodule
